pc_gen: RTL and testbench

//  Fetch-stage PC generator; sits directly downstream of branch_target. Each cycle it selects
//  the next imem address from BTarg/PCSel_bit1, JAL/JALR targets or PC+4, and registers it.
//  It kills the wrong-path instruction after every redirect and halts on misaligned targets.

---
 rtl/pc_gen.sv | 147 ++++++++++++++
 tb/tb_pc_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: selects the next imem address (JALR > branch > JAL > PC+4),
// kills the wrong-path fetch after each redirect, and halts on a misaligned target.
module pc_gen #(
  parameter int unsigned            XLEN     = 32,
  parameter logic [XLEN-1:0]        RESET_PC = 32'h0000_2000,
  parameter int unsigned            CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             PCSel_bit1,
  input  logic [XLEN-1:0]  BTarg,
  input  logic             jal_valid,
  input  logic [XLEN-1:0]  JTarg,
  input  logic             jalr_valid,
  input  logic [XLEN-1:0]  JALRTarg,
  output logic [XLEN-1:0]  pc_out,
  output logic [XLEN-1:0]  pc_fetch,
  output logic             inst_valid,
  output logic             redirect,
  output logic             misalign,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_out_q, pc_out_d;
  logic [XLEN-1:0]   pc_fetch_q, pc_fetch_d;
  logic              inst_valid_q, inst_valid_d;
  logic              misalign_q, misalign_d;
  logic [CNT_W-1:0]  redirect_cnt_q, redirect_cnt_d;

  logic [XLEN-1:0]   jalr_targ;
  logic [XLEN-1:0]   next_pc;
  logic              fetching;
  logic              next_misaligned;
  logic              redirect_c;

  // JALR target with bit 0 forced low; only bits [1:0] left to check afterwards
  assign jalr_targ = JALRTarg & ~{{(XLEN-1){1'b0}}, 1'b1};

  // Next-PC select: JALR beats a taken branch, which beats JAL, else sequential
  always_comb begin
    next_pc = pc_out_q + XLEN'(4);
    if (jalr_valid) begin
      next_pc = jalr_targ;
    end else if (PCSel_bit1) begin
      next_pc = BTarg;
    end else if (jal_valid) begin
      next_pc = JTarg;
    end
  end

  // A fetch advances only in BOOT/RUN and when downstream is ready
  assign fetching        = ((state_q == BOOT) || (state_q == RUN)) && !stall;
  assign next_misaligned = fetching && (next_pc[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: BOOT leaves after the first fetch, misalignment parks us in HALT
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: begin
        if (!stall) begin
          state_d = next_misaligned ? HALT : RUN;
        end
      end
      RUN: begin
        if (next_misaligned) begin
          state_d = HALT;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // FSM outputs: redirects are only acknowledged once running
  always_comb begin
    redirect_c = 1'b0;
    if (state_q == RUN && !stall) begin
      redirect_c = jalr_valid | PCSel_bit1 | jal_valid;
    end
  end

  // Datapath next values: advance PC, kill the in-flight fetch on redirect, count redirects
  always_comb begin
    pc_out_d       = pc_out_q;
    pc_fetch_d     = pc_fetch_q;
    inst_valid_d   = inst_valid_q;
    misalign_d     = misalign_q;
    redirect_cnt_d = redirect_cnt_q;
    if (fetching) begin
      pc_fetch_d = pc_out_q;
      if (next_misaligned) begin
        misalign_d   = 1'b1;
        inst_valid_d = 1'b0;
      end else begin
        pc_out_d     = next_pc;
        inst_valid_d = !redirect_c;
      end
      if (redirect_c) begin
        redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
      end
    end else if (state_q == HALT) begin
      inst_valid_d = 1'b0;
    end
  end

  // Datapath registers; reset takes precedence over stall and redirects
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out_q       <= RESET_PC;
      pc_fetch_q     <= '0;
      inst_valid_q   <= 1'b0;
      misalign_q     <= 1'b0;
      redirect_cnt_q <= '0;
    end else begin
      pc_out_q       <= pc_out_d;
      pc_fetch_q     <= pc_fetch_d;
      inst_valid_q   <= inst_valid_d;
      misalign_q     <= misalign_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign pc_out       = pc_out_q;
  assign pc_fetch     = pc_fetch_q;
  assign inst_valid   = inst_valid_q;
  assign redirect     = redirect_c;
  assign misalign     = misalign_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen with a scoreboard queue and a decoupled monitor.
// redirect_cnt is narrowed to 3 bits so its wrap is reachable in a short run.
module tb_pc_gen;

  localparam int XLEN  = 32;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst;
  logic             stall;
  logic             PCSel_bit1;
  logic [XLEN-1:0]  BTarg;
  logic             jal_valid;
  logic [XLEN-1:0]  JTarg;
  logic             jalr_valid;
  logic [XLEN-1:0]  JALRTarg;
  logic [XLEN-1:0]  pc_out;
  logic [XLEN-1:0]  pc_fetch;
  logic             inst_valid;
  logic             redirect;
  logic             misalign;
  logic [CNT_W-1:0] redirect_cnt;

  pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (32'h0000_2000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .PCSel_bit1   (PCSel_bit1),
    .BTarg        (BTarg),
    .jal_valid    (jal_valid),
    .JTarg        (JTarg),
    .jalr_valid   (jalr_valid),
    .JALRTarg     (JALRTarg),
    .pc_out       (pc_out),
    .pc_fetch     (pc_fetch),
    .inst_valid   (inst_valid),
    .redirect     (redirect),
    .misalign     (misalign),
    .redirect_cnt (redirect_cnt)
  );

  // Clock starts high so the first sampling negedge falls inside cycle 0
  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    int               id;
    logic             chk;
    logic [XLEN-1:0]  pc_out;
    logic [XLEN-1:0]  pc_fetch;
    logic             iv;
    logic             rd;
    logic             mis;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   vec_id = 0;

  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", id, name, act, req);
    end
  endtask

  // Monitor: mid-cycle, state reflects the last edge and inputs are settled
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk) begin
        check("pc_out",       e.id, pc_out,              e.pc_out);
        check("pc_fetch",     e.id, pc_fetch,            e.pc_fetch);
        check("inst_valid",   e.id, 32'(inst_valid),     32'(e.iv));
        check("redirect",     e.id, 32'(redirect),       32'(e.rd));
        check("misalign",     e.id, 32'(misalign),       32'(e.mis));
        check("redirect_cnt", e.id, 32'(redirect_cnt),   32'(e.cnt));
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle
  task automatic cyc(input logic r, input logic st,
                     input logic bs, input logic [31:0] bt,
                     input logic js, input logic [31:0] jt,
                     input logic jrs, input logic [31:0] jrt,
                     input logic chk,
                     input logic [31:0] e_pc, input logic [31:0] e_fetch,
                     input logic e_iv, input logic e_rd, input logic e_mis,
                     input logic [CNT_W-1:0] e_cnt);
    exp_t e;
    rst = r; stall = st;
    PCSel_bit1 = bs; BTarg = bt;
    jal_valid = js;  JTarg = jt;
    jalr_valid = jrs; JALRTarg = jrt;
    e.id = vec_id; e.chk = chk;
    e.pc_out = e_pc; e.pc_fetch = e_fetch;
    e.iv = e_iv; e.rd = e_rd; e.mis = e_mis; e.cnt = e_cnt;
    exp_q.push_back(e);
    vec_id++;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int budget;
    //   rst st  br bt            jal jt            jalr jrt          chk  pc_out        pc_fetch      iv rd ms cnt
    // Reset and sequential fetch
    cyc(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0, 3'd0);
    cyc(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h2000,     32'h0,        0, 0, 0, 3'd0);
    cyc(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h2000,     32'h0,        0, 0, 0, 3'd0);
    cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h2000,     32'h0,        0, 0, 0, 3'd0);
    cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h2004,     32'h2000,     1, 0, 0, 3'd0);
    cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h2008,     32'h2004,     1, 0, 0, 3'd0);
    // Branch beats JAL
    cyc(0, 0, 1, 32'h2100,     1, 32'h3000,     0, 32'h0,        1, 32'h200C,     32'h2008,     1, 1, 0, 3'd0);
    cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h2100,     32'h200C,     0, 0, 0, 3'd1);
    cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h2104,     32'h2100,     1, 0, 0, 3'd1);
    // JALR beats branch, bit 0 cleared
    cyc(0, 0, 1, 32'h2500,     0, 32'h0,        1, 32'h2201,     1, 32'h2108,     32'h2104,     1, 1, 0, 3'd1);
    cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h2200,     32'h2108,     0, 0, 0, 3'd2);
    // Back-to-back redirects, second arrives with inst_valid=0
    cyc(0, 0, 0, 32'h0,        1, 32'h2400,     0, 32'h0,        1, 32'h2204,     32'h2200,     1, 1, 0, 3'd2);
    cyc(0, 0, 0, 32'h0,        1, 32'h2500,     0, 32'h0,        1, 32'h2400,     32'h2204,     0, 1, 0, 3'd3);
    cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h2500,     32'h2400,     0, 0, 0, 3'd4);
    // Stall with branch held for 3 cycles, taken once released
    cyc(0, 1, 1, 32'h2600,     0, 32'h0,        0, 32'h0,        1, 32'h2504,     32'h2500,     1, 0, 0, 3'd4);
    cyc(0, 1, 1, 32'h2600,     0, 32'h0,        0, 32'h0,        1, 32'h2504,     32'h2500,     1, 0, 0, 3'd4);
    cyc(0, 1, 1, 32'h2600,     0, 32'h0,        0, 32'h0,        1, 32'h2504,     32'h2500,     1, 0, 0, 3'd4);
    cyc(0, 0, 1, 32'h2600,     0, 32'h0,        0, 32'h0,        1, 32'h2504,     32'h2500,     1, 1, 0, 3'd4);
    cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h2600,     32'h2504,     0, 0, 0, 3'd5);
    // PC wrap at top of address space
    cyc(0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0,       1, 32'h2604,     32'h2600,     1, 1, 0, 3'd5);
    cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'hFFFF_FFFC, 32'h2604,    0, 0, 0, 3'd6);
    cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h0000_0000, 32'hFFFF_FFFC, 1, 0, 0, 3'd6);
    // Counter wrap 7 -> 0
    cyc(0, 0, 0, 32'h0,        1, 32'h2000,     0, 32'h0,        1, 32'h4,        32'h0,        1, 1, 0, 3'd6);
    cyc(0, 0, 0, 32'h0,        1, 32'h2100,     0, 32'h0,        1, 32'h2000,     32'h4,        0, 1, 0, 3'd7);
    cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h2100,     32'h2000,     0, 0, 0, 3'd0);
    // Misaligned branch target halts; redirects ignored in HALT
    cyc(0, 0, 1, 32'h2102,     0, 32'h0,        0, 32'h0,        1, 32'h2104,     32'h2100,     1, 1, 0, 3'd0);
    cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h2104,     32'h2104,     0, 0, 1, 3'd1);
    cyc(0, 0, 0, 32'h0,        1, 32'h3000,     0, 32'h0,        1, 32'h2104,     32'h2104,     0, 0, 1, 3'd1);
    // Reset (with stall high) recovers
    cyc(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h2104,     32'h2104,     0, 0, 1, 3'd1);
    cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h2000,     32'h0,        0, 0, 0, 3'd0);
    cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h2004,     32'h2000,     1, 0, 0, 3'd0);

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
